// File: rtl/mem_access_ctrl.sv
// Data-memory access controller: turns EX/MEM load/store requests into a req/ack handshake and stalls the pipeline meanwhile.
// Define MEM_TIMEOUT_EN to abort accesses that see no mem_ack within TIMEOUT_CYCLES busy cycles.
module mem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [15:0] Addr,
    input  logic [15:0] WriteData,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall,
    output logic [15:0] ReadData,
    output logic        rd_valid,
    output logic        access_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  r_state;
    logic        r_wr;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic [15:0] r_readData;
    logic        r_rdValid;
    logic        r_accessErr;

    logic w_single;
    logic w_conflict;
    logic w_timeout;
    logic w_unused;

    assign w_single   = MemRead ^ MemWrite;
    assign w_conflict = MemRead & MemWrite;
    assign w_unused   = Addr[0];

    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 255)) begin : g_badTimeoutCycles
    end

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    logic [7:0] r_timeoutCnt;

    // Fires in the busy cycle whose missing ack would bring the count up to the limit; an ack in that cycle wins.
    assign w_timeout = (r_state == S_BUSY) && !mem_ack && ((r_timeoutCnt + 8'd1) == TIMEOUT_LIMIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_timeoutCnt <= 8'd0;
        end else if (r_state == S_IDLE) begin
            r_timeoutCnt <= 8'd0;
        end else if ((r_state == S_BUSY) && !mem_ack) begin
            r_timeoutCnt <= r_timeoutCnt + 8'd1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_wr        <= 1'b0;
            r_addr      <= 16'h0000;
            r_wdata     <= 16'h0000;
            r_readData  <= 16'h0000;
            r_rdValid   <= 1'b0;
            r_accessErr <= 1'b0;
        end else begin
            r_rdValid   <= 1'b0;
            r_accessErr <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_single) begin
                        r_wr    <= MemWrite;
                        r_addr  <= {Addr[15:1], 1'b0};
                        r_wdata <= WriteData;
                        r_state <= S_BUSY;
                    end else if (w_conflict) begin
                        r_accessErr <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_BUSY: begin
                    if (mem_ack) begin
                        if (!r_wr) begin
                            r_readData <= mem_rdata;
                            r_rdValid  <= 1'b1;
                        end
                        r_state <= S_DONE;
                    end else if (w_timeout) begin
                        if (!r_wr) begin
                            r_readData <= 16'h0000;
                            r_rdValid  <= 1'b1;
                        end
                        r_accessErr <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                // DONE lets the pipeline advance past the still-held request without re-issuing it.
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A conflicting request also stalls for its IDLE cycle so that it reports exactly one stall cycle.
    assign stall      = ((r_state == S_IDLE) && (MemRead | MemWrite)) || (r_state == S_BUSY);
    assign mem_req    = (r_state == S_BUSY);
    assign mem_wr     = r_wr;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign ReadData   = r_readData;
    assign rd_valid   = r_rdValid;
    assign access_err = r_accessErr;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl: loads, stores, conflicts, back-to-back traffic, reset and timeout.
// Built with TIMEOUT_CYCLES=4; the timeout scenario checks abort behaviour when MEM_TIMEOUT_EN is defined, indefinite wait otherwise.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [15:0] Addr = 16'h0000;
    logic [15:0] WriteData = 16'h0000;
    logic [15:0] mem_rdata = 16'hDEAD;
    logic        mem_ack = 1'b0;
    logic        mem_req;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        stall;
    logic [15:0] ReadData;
    logic        rd_valid;
    logic        access_err;

    int checkCount = 0;
    int errorCount = 0;

    int          obsStall;
    int          obsReqCycles;
    int          obsReqStarts;
    int          obsRdValid;
    int          obsErr;
    logic [15:0] obsAddr;
    logic [15:0] obsWdata;
    logic        obsWr;
    logic        obsFirstReq;
    logic        obsFinished;
    int          firstStarts;

    mem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Addr       (Addr),
        .WriteData  (WriteData),
        .mem_req    (mem_req),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .stall      (stall),
        .ReadData   (ReadData),
        .rd_valid   (rd_valid),
        .access_err (access_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Presents one EX/MEM request, held while stall is high and through the cycle stall drops, like the pipeline register.
    // The memory acks in the busy cycle with index ackAt (0 = first busy cycle, -1 = never).
    task automatic applyStimulus(input logic rd, input logic wr, input logic [15:0] addr,
                                 input logic [15:0] wdata, input logic [15:0] rdata, input int ackAt);
        int   busyCount;
        logic prevReq;
        busyCount    = 0;
        prevReq      = 1'b0;
        obsStall     = 0;
        obsReqCycles = 0;
        obsReqStarts = 0;
        obsRdValid   = 0;
        obsErr       = 0;
        obsAddr      = 16'h0000;
        obsWdata     = 16'h0000;
        obsWr        = 1'b0;
        obsFirstReq  = 1'b0;
        obsFinished  = 1'b0;
        for (int cyc = 0; cyc < 40 && !obsFinished; cyc++) begin
            MemRead   = rd;
            MemWrite  = wr;
            Addr      = addr;
            WriteData = wdata;
            mem_ack   = mem_req && (busyCount == ackAt);
            mem_rdata = mem_ack ? rdata : 16'hDEAD;
            #1;
            if (cyc == 0) obsFirstReq = mem_req;
            if (stall) obsStall++;
            if (mem_req) begin
                if (!prevReq) obsReqStarts++;
                obsReqCycles++;
                busyCount++;
                obsAddr  = mem_addr;
                obsWdata = mem_wdata;
                obsWr    = mem_wr;
            end
            prevReq = mem_req;
            if (rd_valid) obsRdValid++;
            if (access_err) obsErr++;
            if (!stall) obsFinished = 1'b1;
            @(negedge clk);
        end
        mem_ack   = 1'b0;
        mem_rdata = 16'hDEAD;
    endtask

    task automatic idleCycles(input int n);
        obsRdValid   = 0;
        obsErr       = 0;
        obsReqCycles = 0;
        for (int i = 0; i < n; i++) begin
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            #1;
            if (rd_valid) obsRdValid++;
            if (access_err) obsErr++;
            if (mem_req) obsReqCycles++;
            @(negedge clk);
        end
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput("rst mem_req", mem_req, 1'b0);
        checkOutput("rst mem_wr", mem_wr, 1'b0);
        checkOutput("rst mem_addr", mem_addr, 16'h0000);
        checkOutput("rst mem_wdata", mem_wdata, 16'h0000);
        checkOutput("rst ReadData", ReadData, 16'h0000);
        checkOutput("rst rd_valid", rd_valid, 1'b0);
        checkOutput("rst access_err", access_err, 1'b0);
        checkOutput("rst stall idle", stall, 1'b0);
        MemRead = 1'b1;
        #1;
        checkOutput("rst stall follows req", stall, 1'b1);
        MemRead = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        applyStimulus(1'b1, 1'b0, 16'h0041, 16'h0000, 16'hBEEF, 2);
        checkOutput("rd stall cycles", obsStall, 4);
        checkOutput("rd req cycles", obsReqCycles, 3);
        checkOutput("rd req starts", obsReqStarts, 1);
        checkOutput("rd mem_addr", obsAddr, 16'h0040);
        checkOutput("rd mem_wr", obsWr, 1'b0);
        checkOutput("rd rd_valid", obsRdValid, 1);
        checkOutput("rd access_err", obsErr, 0);
        checkOutput("rd ReadData", ReadData, 16'hBEEF);
        idleCycles(2);
        checkOutput("rd strobe one cycle", obsRdValid, 0);

        applyStimulus(1'b0, 1'b1, 16'h0010, 16'h1234, 16'h5A5A, 0);
        checkOutput("wr stall cycles", obsStall, 2);
        checkOutput("wr req cycles", obsReqCycles, 1);
        checkOutput("wr mem_wr", obsWr, 1'b1);
        checkOutput("wr mem_wdata", obsWdata, 16'h1234);
        checkOutput("wr mem_addr", obsAddr, 16'h0010);
        checkOutput("wr rd_valid", obsRdValid, 0);
        checkOutput("wr ReadData kept", ReadData, 16'hBEEF);

        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 16'h7777;
        @(negedge clk);
        #1;
        checkOutput("idle ack ReadData", ReadData, 16'hBEEF);
        checkOutput("idle ack rd_valid", rd_valid, 1'b0);
        checkOutput("idle ack mem_req", mem_req, 1'b0);
        mem_ack   = 1'b0;
        mem_rdata = 16'hDEAD;
        @(negedge clk);

        applyStimulus(1'b1, 1'b1, 16'h0022, 16'h9999, 16'h3333, 0);
        checkOutput("both stall cycles", obsStall, 1);
        checkOutput("both req cycles", obsReqCycles, 0);
        checkOutput("both access_err", obsErr, 1);
        checkOutput("both rd_valid", obsRdValid, 0);
        checkOutput("both ReadData kept", ReadData, 16'hBEEF);
        idleCycles(1);
        checkOutput("both err one cycle", obsErr, 0);

        applyStimulus(1'b1, 1'b0, 16'h0123, 16'h0000, 16'hCAFE, 1);
        firstStarts = obsReqStarts;
        checkOutput("b2b ld mem_addr", obsAddr, 16'h0122);
        checkOutput("b2b ld rd_valid", obsRdValid, 1);
        checkOutput("b2b ld ReadData", ReadData, 16'hCAFE);
        applyStimulus(1'b0, 1'b1, 16'h0200, 16'h5555, 16'h0000, 0);
        checkOutput("b2b idle gap", obsFirstReq, 1'b0);
        checkOutput("b2b st req starts", obsReqStarts, 1);
        checkOutput("b2b total transactions", firstStarts + obsReqStarts, 2);
        checkOutput("b2b st mem_addr", obsAddr, 16'h0200);
        checkOutput("b2b st mem_wdata", obsWdata, 16'h5555);
        checkOutput("b2b st stall cycles", obsStall, 2);
        checkOutput("b2b st rd_valid", obsRdValid, 0);
        checkOutput("b2b st ReadData kept", ReadData, 16'hCAFE);
        idleCycles(2);
        checkOutput("b2b no reissue", obsReqCycles, 0);

        applyStimulus(1'b1, 1'b0, 16'h0031, 16'h0000, 16'h4321, 3);
        checkOutput("late ack stall cycles", obsStall, 5);
        checkOutput("late ack req cycles", obsReqCycles, 4);
        checkOutput("late ack access_err", obsErr, 0);
        checkOutput("late ack rd_valid", obsRdValid, 1);
        checkOutput("late ack ReadData", ReadData, 16'h4321);

        MemRead = 1'b1;
        Addr    = 16'h0051;
        @(negedge clk);
        #1;
        checkOutput("mid rst busy mem_req", mem_req, 1'b1);
        rst = 1'b0;
        #1;
        checkOutput("mid rst mem_req", mem_req, 1'b0);
        checkOutput("mid rst ReadData", ReadData, 16'h0000);
        checkOutput("mid rst stall", stall, 1'b1);
        MemRead = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        idleCycles(3);
        checkOutput("mid rst rd_valid", obsRdValid, 0);
        checkOutput("mid rst access_err", obsErr, 0);
        checkOutput("mid rst mem_req after", obsReqCycles, 0);

        applyStimulus(1'b1, 1'b0, 16'h0031, 16'h0000, 16'h6789, 0);
        checkOutput("pre timeout ReadData", ReadData, 16'h6789);
`ifdef MEM_TIMEOUT_EN
        applyStimulus(1'b1, 1'b0, 16'h0008, 16'h0000, 16'h1111, -1);
        checkOutput("to finished", obsFinished, 1'b1);
        checkOutput("to req cycles", obsReqCycles, 4);
        checkOutput("to stall cycles", obsStall, 5);
        checkOutput("to access_err", obsErr, 1);
        checkOutput("to rd_valid", obsRdValid, 1);
        checkOutput("to ReadData", ReadData, 16'h0000);
        idleCycles(1);
`else
        applyStimulus(1'b1, 1'b0, 16'h0008, 16'h0000, 16'h1111, -1);
        checkOutput("no to still waiting", obsFinished, 1'b0);
        checkOutput("no to access_err", obsErr, 0);
        checkOutput("no to rd_valid", obsRdValid, 0);
        #1;
        checkOutput("no to mem_req", mem_req, 1'b1);
        checkOutput("no to ReadData kept", ReadData, 16'h6789);
        MemRead = 1'b0;
        rst     = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        idleCycles(1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
